// File: rtl/bitsum_mask_sched_pkg.sv
// Shared definitions for the mask popcount scheduler: slice width,
// FSM state encoding and the derived-width helpers.
package bitsum_mask_sched_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold a count of 0..mask_w set bits.
    function automatic int count_width(input int mask_w);
        return $clog2(mask_w + 1);
    endfunction

    // Bits needed to name one of nreq requesters (at least one bit).
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/bitsum_mask_sched_bitsum15.sv
// bitsum15: 16-input combinational popcount, 7-bit result (0..16).
// Built as a balanced adder tree so the depth stays at four adder levels.
module bitsum15 (
    input  logic [15:0] din,
    output logic [6:0]  cnt
);

    logic [1:0] s1 [8];
    logic [2:0] s2 [4];
    logic [3:0] s3 [2];
    logic [4:0] s4;

    genvar gi;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_lvl1
            assign s1[gi] = {1'b0, din[2*gi]} + {1'b0, din[2*gi+1]};
        end
        for (gi = 0; gi < 4; gi++) begin : g_lvl2
            assign s2[gi] = {1'b0, s1[2*gi]} + {1'b0, s1[2*gi+1]};
        end
        for (gi = 0; gi < 2; gi++) begin : g_lvl3
            assign s3[gi] = {1'b0, s2[2*gi]} + {1'b0, s2[2*gi+1]};
        end
    endgenerate

    assign s4  = {1'b0, s3[0]} + {1'b0, s3[1]};
    assign cnt = {2'b00, s4};

endmodule

// File: rtl/bitsum_mask_sched.sv
// bitsum_mask_sched: shares one 16-bit popcount between NREQ requesters.
// A granted mask is walked 16 bits per cycle, the hit count accumulated,
// then compared with the requester's threshold and offered on res_*.
module bitsum_mask_sched
    import bitsum_mask_sched_pkg::*;
#(
    parameter  int MASK_W = 128,
    parameter  int NREQ   = 2,
    localparam int NS     = MASK_W / SLICE_W,
    localparam int CW     = count_width(MASK_W),
    localparam int IW     = id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*MASK_W-1:0] req_mask,
    input  logic [NREQ*CW-1:0]     req_thr,
    output logic [NREQ-1:0]        req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CW-1:0]          res_count,
    output logic [IW-1:0]          res_id,
    output logic                   res_over,
    output logic                   busy
);

    localparam int KW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NS - 1);
    localparam logic [IW-1:0] ID_LAST = IW'(NREQ - 1);

    state_t              state_reg, state_next;
    logic [MASK_W-1:0]   shadow_reg;
    logic [CW-1:0]       thr_reg;
    logic [CW-1:0]       acc_reg;
    logic [IW-1:0]       id_reg;
    logic [IW-1:0]       rr_reg;
    logic [KW-1:0]       k_reg;

    logic [MASK_W-1:0]   mask_arr  [NREQ];
    logic [CW-1:0]       thr_arr   [NREQ];
    logic [SLICE_W-1:0]  slice_arr [NS];

    logic                lo_found, hi_found, grant_found;
    logic [IW-1:0]       lo_idx, hi_idx, grant_idx;
    logic [6:0]          pc_full;
    logic [1:0]          unused_pc_hi;

    genvar gi;

    // Unpack the flat request buses and the shadow slices into arrays
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign mask_arr[gi]  = req_mask[gi*MASK_W +: MASK_W];
            assign thr_arr[gi]   = req_thr[gi*CW +: CW];
            // A grant pulse is only meaningful when the capture edge can
            // actually happen, so it is held off while reset is asserted.
            assign req_ready[gi] = rstn && (state_reg == IDLE) && grant_found
                                   && (grant_idx == IW'(gi));
        end
        for (gi = 0; gi < NS; gi++) begin : g_slice
            assign slice_arr[gi] = shadow_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    // Round-robin pick: lowest valid index at or after rr, else wrap to lowest
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = IW'(i);
            end
            if (req_valid[i] && (IW'(i) >= rr_reg)) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
        end
    end

    assign grant_found = lo_found;
    assign grant_idx   = hi_found ? hi_idx : lo_idx;

    bitsum15 u_bitsum (
        .din (slice_arr[k_reg]),
        .cnt (pc_full)
    );

    // A slice holds at most 16 ones, so bits 6:5 of the popcount stay zero.
    assign unused_pc_hi = pc_full[6:5];

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: grant -> walk NS slices -> hold result until accepted
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant_found)       state_next = SUM;
            SUM:  if (k_reg == K_LAST)   state_next = DONE;
            DONE: if (res_ready)         state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Datapath: capture on grant, accumulate one slice per SUM cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_reg <= '0;
            thr_reg    <= '0;
            acc_reg    <= '0;
            id_reg     <= '0;
            rr_reg     <= '0;
            k_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        shadow_reg <= mask_arr[grant_idx];
                        thr_reg    <= thr_arr[grant_idx];
                        id_reg     <= grant_idx;
                        acc_reg    <= '0;
                        k_reg      <= '0;
                        rr_reg     <= (grant_idx == ID_LAST) ? '0 : grant_idx + 1'b1;
                    end
                end
                SUM: begin
                    acc_reg <= acc_reg + CW'(pc_full[4:0]);
                    k_reg   <= (k_reg == K_LAST) ? '0 : k_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result port is driven only in DONE so it reads zero everywhere else
    assign res_valid = (state_reg == DONE);
    assign res_count = res_valid ? acc_reg : '0;
    assign res_id    = res_valid ? id_reg  : '0;
    assign res_over  = res_valid && (acc_reg >= thr_reg);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_bitsum_mask_sched.sv
// Testbench for bitsum_mask_sched: directed scenarios plus a random phase,
// all checked every cycle against a transaction-level reference model.
module tb_bitsum_mask_sched;

    localparam int MASK_W = 128;
    localparam int NREQ   = 2;
    localparam int NS     = MASK_W / 16;
    localparam int CW     = 8;
    localparam int IW     = 1;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*MASK_W-1:0] req_mask;
    logic [NREQ*CW-1:0]     req_thr;
    logic [NREQ-1:0]        req_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [CW-1:0]          res_count;
    logic [IW-1:0]          res_id;
    logic                   res_over;
    logic                   busy;

    bitsum_mask_sched #(.MASK_W(MASK_W), .NREQ(NREQ)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_mask  (req_mask),
        .req_thr   (req_thr),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_count (res_count),
        .res_id    (res_id),
        .res_over  (res_over),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one expected result per accepted request
    typedef struct {
        int cnt;
        int id;
        bit over;
        int gcyc;
    } exp_t;

    exp_t sb[$];
    int   model_rr;
    bit   model_busy;
    int   cyc;

    // Per-tick observations used by the directed steps
    bit   saw_grant;
    int   saw_grant_id;
    bit   saw_hs;
    int   hs_cnt;
    int   hs_id;
    bit   hs_over;
    bit   s_valid;
    int   s_count;
    int   grant_ids[$];
    int   grant_cycs[$];

    bit              rand_mode;
    logic [NREQ-1:0] prev_rdy;
    bit              pend [NREQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Winner by the arbitration rule: first valid index scanning from rr
    function automatic int pick(input logic [NREQ-1:0] v, input int rr);
        for (int j = 0; j < NREQ; j++) begin
            int idx = (rr + j) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int who, input logic [MASK_W-1:0] m, input logic [CW-1:0] t);
        req_mask[who*MASK_W +: MASK_W] = m;
        req_thr[who*CW +: CW]          = t;
        req_valid[who]                 = 1'b1;
    endtask

    task automatic random_drive();
        logic [MASK_W-1:0] m;
        logic [CW-1:0]     t;
        for (int i = 0; i < NREQ; i++) begin
            if (prev_rdy[i]) begin
                req_valid[i] = 1'b0;
                pend[i]      = 1'b0;
            end else if (pend[i]) begin
                if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                    pend[i]      = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                for (int w = 0; w < MASK_W / 32; w++) m[w*32 +: 32] = $urandom();
                case ($urandom_range(0, 3))
                    0: m = m & {MASK_W/32{$urandom()}};
                    1: m = '1;
                    default: ;
                endcase
                case ($urandom_range(0, 4))
                    0:       t = '0;
                    1:       t = CW'($urandom_range(MASK_W + 1, 255));
                    default: t = CW'($urandom_range(20, 110));
                endcase
                set_req(i, m, t);
                pend[i] = 1'b1;
            end
        end
        res_ready = ($urandom_range(0, 2) != 0);
    endtask

    // One clock cycle: optional random drive at negedge, sample and check
    // 1 time unit later, return just after the following rising edge.
    task automatic tick();
        logic [NREQ-1:0] exp_rdy;
        int              w;
        bit              exp_valid;
        exp_t            e;
        @(negedge clk);
        if (rand_mode) random_drive();
        #1;
        cyc++;
        saw_grant = 1'b0;
        saw_hs    = 1'b0;
        s_valid   = res_valid;
        s_count   = int'(res_count);
        exp_rdy   = '0;
        w         = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                saw_grant    = 1'b1;
                saw_grant_id = i;
            end
        end
        if (!rstn) begin
            sb.delete();
            model_busy = 1'b0;
            model_rr   = 0;
            chk("rst_req_ready", req_ready, '0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
            prev_rdy = '0;
        end else begin
            if (!model_busy) begin
                w = pick(req_valid, model_rr);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, model_busy);
            exp_valid = model_busy && (sb.size() > 0) && (cyc >= sb[0].gcyc + NS + 1);
            chk("res_valid", res_valid, exp_valid);
            if (res_valid && sb.size() > 0) begin
                chk("res_count", res_count, sb[0].cnt);
                chk("res_id", res_id, sb[0].id);
                chk("res_over", res_over, sb[0].over);
                if (res_ready) begin
                    saw_hs  = 1'b1;
                    hs_cnt  = int'(res_count);
                    hs_id   = int'(res_id);
                    hs_over = res_over;
                    $display("t=%0t result id=%0d count=%0d over=%0b", $time, res_id, res_count, res_over);
                    void'(sb.pop_front());
                    model_busy = 1'b0;
                end
            end
            if (w >= 0) begin
                e.cnt  = $countones(req_mask[w*MASK_W +: MASK_W]);
                e.id   = w;
                e.over = (e.cnt >= int'(req_thr[w*CW +: CW]));
                e.gcyc = cyc;
                sb.push_back(e);
                model_busy = 1'b1;
                model_rr   = (w + 1) % NREQ;
                grant_ids.push_back(w);
                grant_cycs.push_back(cyc);
                $display("t=%0t grant id=%0d expect count=%0d over=%0b", $time, w, e.cnt, e.over);
            end
            prev_rdy = req_ready;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic await_grant(input int who, input int bound);
        bit got = 1'b0;
        for (int n = 0; n < bound && !got; n++) begin
            tick();
            if (saw_grant && saw_grant_id == who) got = 1'b1;
        end
        chk("grant_seen", got, 1);
        req_valid[who] = 1'b0;
    endtask

    task automatic await_result(input int bound);
        bit got = 1'b0;
        for (int n = 0; n < bound && !got; n++) begin
            tick();
            if (saw_hs) got = 1'b1;
        end
        chk("result_seen", got, 1);
    endtask

    task automatic reset_pulse();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MASK_W-1:0] m0;
        logic [MASK_W-1:0] m1;
        bit                got;

        rstn      = 1'b0;
        req_valid = '0;
        req_mask  = '0;
        req_thr   = '0;
        res_ready = 1'b0;
        rand_mode = 1'b0;
        cyc       = 0;
        model_rr  = 0;
        model_busy = 1'b0;
        prev_rdy  = '0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

        // Reset state before any clock edge
        #2;
        chk("init_res_valid", res_valid, 0);
        chk("init_res_count", res_count, 0);
        chk("init_res_id", res_id, 0);
        chk("init_res_over", res_over, 0);
        chk("init_busy", busy, 0);
        chk("init_req_ready", req_ready, '0);
        tick();
        tick();
        rstn = 1'b1;

        // All-ones mask, thr=100: one grant pulse, count 128, over
        res_ready = 1'b1;
        grant_ids.delete();
        set_req(0, '1, 8'd100);
        await_grant(0, 5);
        await_result(20);
        chk("t1_pulses", grant_ids.size(), 1);
        chk("t1_count", hs_cnt, 128);
        chk("t1_over", hs_over, 1);
        chk("t1_id", hs_id, 0);

        // Bits 0, 63, 64 set, thr=4: slice order covers both halves
        m0 = 128'h0000_0000_0000_0001_8000_0000_0000_0001;
        set_req(0, m0, 8'd4);
        await_grant(0, 5);
        await_result(20);
        chk("t2_count", hs_cnt, 3);
        chk("t2_over", hs_over, 0);

        // thr=0 with empty mask: over must still be set
        set_req(0, '0, 8'd0);
        await_grant(0, 5);
        await_result(20);
        chk("t3_count", hs_cnt, 0);
        chk("t3_over", hs_over, 1);

        // thr beyond MASK_W: never over, even with every bit set
        set_req(1, '1, 8'd200);
        await_grant(1, 5);
        await_result(20);
        chk("t4_count", hs_cnt, 128);
        chk("t4_over", hs_over, 0);
        chk("t4_id", hs_id, 1);

        // Both requesters held valid from rr=0: alternate, NS+2 apart
        reset_pulse();
        grant_ids.delete();
        grant_cycs.delete();
        m0 = 128'hF0F0_0000_1234_5678_0000_0000_FFFF_0001;
        m1 = 128'h0000_0000_0000_0000_0000_0000_0000_00FF;
        set_req(0, m0, 8'd30);
        set_req(1, m1, 8'd8);
        res_ready = 1'b1;
        for (int n = 0; n < 80 && grant_ids.size() < 4; n++) tick();
        req_valid = '0;
        chk("t5_ngrants", grant_ids.size(), 4);
        if (grant_ids.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("t5_order", grant_ids[i], i % 2);
            for (int i = 0; i < 3; i++) chk("t5_spacing", grant_cycs[i+1] - grant_cycs[i], NS + 2);
        end
        await_result(20);
        chk("t5_last_id", hs_id, 1);
        chk("t5_last_count", hs_cnt, 8);

        // Consumer stalls in DONE: result holds, no new grant meanwhile
        m0 = 128'h0000_0000_0000_0000_0000_0000_0000_001F;
        set_req(0, m0, 8'd5);
        res_ready = 1'b0;
        await_grant(0, 5);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            if (s_valid) got = 1'b1;
        end
        chk("t6_valid_seen", got, 1);
        set_req(1, '1, 8'd1);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("t6_hold_valid", s_valid, 1);
            chk("t6_hold_count", s_count, 5);
            chk("t6_no_grant", saw_grant, 0);
        end
        res_ready = 1'b1;
        tick();
        chk("t6_handshake", saw_hs, 1);
        tick();
        chk("t6_next_grant", saw_grant, 1);
        chk("t6_next_id", saw_grant_id, 1);
        req_valid[1] = 1'b0;
        await_result(20);

        // Reset during SUM slice 4 discards the request
        reset_pulse();
        m0 = 128'hFFFF_FFFF_0000_0000_0000_0000_0000_0000;
        m1 = 128'h0000_0000_0000_0000_0000_0000_0000_0707;
        set_req(0, m0, 8'd10);
        await_grant(0, 5);
        set_req(1, m1, 8'd7);
        for (int n = 0; n < 4; n++) tick();
        rstn = 1'b0;
        #1;
        chk("t7_res_valid", res_valid, 0);
        chk("t7_res_count", res_count, 0);
        chk("t7_res_id", res_id, 0);
        chk("t7_res_over", res_over, 0);
        chk("t7_busy", busy, 0);
        chk("t7_req_ready", req_ready, '0);
        tick();
        rstn = 1'b1;
        tick();
        chk("t7_grant_after_rst", saw_grant, 1);
        chk("t7_grant_id", saw_grant_id, 1);
        req_valid[1] = 1'b0;
        await_result(20);
        chk("t7_count", hs_cnt, 6);
        chk("t7_id", hs_id, 1);
        chk("t7_over", hs_over, 0);

        // Random traffic with random consumer back-pressure
        rand_mode = 1'b1;
        for (int n = 0; n < 400; n++) tick();
        rand_mode = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        for (int n = 0; n < 40 && model_busy; n++) tick();
        tick();
        chk("drain_busy", busy, 0);
        chk("drain_valid", res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
